// File: rtl/multi_rate_tick_gen_if.sv
// multi_rate_tick_gen_if: control/status bundle for the multi-channel tick generator.
// Readback signals exist only when TICK_GEN_READBACK_EN is defined.
interface multi_rate_tick_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 27
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] ch_en;
  logic              sync_restart;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] upd_pend;
`ifdef TICK_GEN_READBACK_EN
  logic [CH_W-1:0]   rd_ch;
  logic [CNT_W-1:0]  rd_div;

  modport master (
    output ch_en, sync_restart, wr_en, wr_ch, wr_div, rd_ch,
    input  tick, clk_out, upd_pend, rd_div
  );
  modport slave (
    input  ch_en, sync_restart, wr_en, wr_ch, wr_div, rd_ch,
    output tick, clk_out, upd_pend, rd_div
  );
`else
  modport master (
    output ch_en, sync_restart, wr_en, wr_ch, wr_div,
    input  tick, clk_out, upd_pend
  );
  modport slave (
    input  ch_en, sync_restart, wr_en, wr_ch, wr_div,
    output tick, clk_out, upd_pend
  );
`endif
endinterface

// File: rtl/multi_rate_tick_gen.sv
// multi_rate_tick_gen: per-channel programmable rate generator producing a
// one-cycle tick and a 50% square wave; divisors reprogrammable glitch-free.
// Optional: define TICK_GEN_READBACK_EN for a registered readback of the
// active divisor of a selected channel.
module multi_rate_tick_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 1_000_000
) (
  input logic                  clk_in,
  input logic                  rst_l,
  multi_rate_tick_gen_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [CNT_W-1:0]  r_active [NUM_CH];
  logic [CNT_W-1:0]  r_pend   [NUM_CH];
  logic [NUM_CH-1:0] r_tick;
  logic [NUM_CH-1:0] r_clk;
  logic [NUM_CH-1:0] r_upd;

  logic [NUM_CH-1:0] w_wr_hit;
  logic [NUM_CH-1:0] w_term;
  logic [NUM_CH-1:0] w_apply;

  // Per-channel write decode, terminal-count detect and divisor-apply points.
  // A pending divisor is applied at any period boundary: terminal count,
  // restart, disable, or while the channel is stalled at divisor 0.
  always_comb begin
    w_wr_hit = '0;
    w_term   = '0;
    w_apply  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_wr_hit[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
      w_term[i]   = !bus.sync_restart && bus.ch_en[i] && (r_active[i] != '0) &&
                    (r_cnt[i] == r_active[i] - CNT_W'(1));
      w_apply[i]  = r_upd[i] && (bus.sync_restart || !bus.ch_en[i] ||
                                 (r_active[i] == '0) || w_term[i]);
    end
  end

  // Counter, tick/clk_out and divisor state; a same-cycle write always lands
  // in pend after any apply, so it wins the upd_pend flag.
  always_ff @(posedge clk_in or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_cnt[i]    <= '0;
        r_active[i] <= CNT_W'(DEFAULT_DIV);
        r_pend[i]   <= CNT_W'(DEFAULT_DIV);
      end
      r_tick <= '0;
      r_clk  <= '0;
      r_upd  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (bus.sync_restart || !bus.ch_en[i]) begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b0;
          r_clk[i]  <= 1'b0;
        end else if (r_active[i] == '0) begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b0;
        end else if (w_term[i]) begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b1;
          r_clk[i]  <= ~r_clk[i];
        end else begin
          r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
          r_tick[i] <= 1'b0;
        end

        if (w_apply[i]) begin
          r_active[i] <= r_pend[i];
        end

        if (w_wr_hit[i]) begin
          r_pend[i] <= bus.wr_div;
          r_upd[i]  <= 1'b1;
        end else if (w_apply[i]) begin
          r_upd[i]  <= 1'b0;
        end
      end
    end
  end

  assign bus.tick     = r_tick;
  assign bus.clk_out  = r_clk;
  assign bus.upd_pend = r_upd;

`ifdef TICK_GEN_READBACK_EN
  logic [CNT_W-1:0] r_rd_div;

  // Registered readback of the selected channel's active divisor.
  always_ff @(posedge clk_in or negedge rst_l) begin
    if (!rst_l) begin
      r_rd_div <= '0;
    end else if (int'(bus.rd_ch) < NUM_CH) begin
      r_rd_div <= r_active[bus.rd_ch];
    end else begin
      r_rd_div <= '0;
    end
  end

  assign bus.rd_div = r_rd_div;
`endif
endmodule
